// File: rtl/spi_host_ctrl_if.sv
// +----------------------------------------------------------------------+
// | spi_host_ctrl_if: request/reply bus and SPI pins of spi_host_ctrl    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface spi_host_ctrl_if #(
  parameter int PKT_BITS = 32
);
  logic                start;
  logic [PKT_BITS-1:0] tx_data;
  logic                ready;
  logic [PKT_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                sclk;
  logic                sc;
  logic                mosi;
  logic                miso;
  logic                rram_busy;

  modport master (
    output start, tx_data, miso, rram_busy,
    input  ready, rx_data, rx_valid, sclk, sc, mosi
  );

  modport slave (
    input  start, tx_data, miso, rram_busy,
    output ready, rx_data, rx_valid, sclk, sc, mosi
  );
endinterface

`default_nettype wire

// File: rtl/spi_host_ctrl.sv
// +----------------------------------------------------------------------+
// | spi_host_ctrl: mode-0 SPI host, one fixed-length packet per request  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_host_ctrl #(
  parameter int PKT_BITS = 32,
  parameter int DIV      = 4
) (
  input  logic              mclk,
  input  logic              rst,
  spi_host_ctrl_if.slave    bus
);

  localparam int c_BIT_W = $clog2(PKT_BITS + 1);
  localparam int c_PH_W  = $clog2(DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [c_PH_W-1:0]   phase_q, phase_d;
  logic [c_BIT_W-1:0]  bit_q, bit_d;
  logic [PKT_BITS-1:0] tx_q, tx_d;
  logic [PKT_BITS-1:0] rx_q, rx_d;
  logic [PKT_BITS-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                ready_q, ready_d;
  logic                sclk_q, sclk_d;
  logic                sc_q, sc_d;
  logic                mosi_q, mosi_d;
  logic [1:0]          busy_sync_q;
  logic                w_phase_end;

  assign w_phase_end = (phase_q == c_PH_W'(DIV - 1));

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ready_q     <= 1'b1;
      sclk_q      <= 1'b0;
      sc_q        <= 1'b0;
      mosi_q      <= 1'b0;
      busy_sync_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ready_q     <= ready_d;
      sclk_q      <= sclk_d;
      sc_q        <= sc_d;
      mosi_q      <= mosi_d;
      busy_sync_q <= {busy_sync_q[0], bus.rram_busy};
    end
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ready_d    = ready_q;
    sclk_d     = sclk_q;
    sc_d       = sc_q;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_d    = bus.tx_data;
          rx_d    = '0;
          bit_d   = '0;
          phase_d = '0;
          ready_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!busy_sync_q[1]) begin
          sc_d    = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[PKT_BITS-1];
          phase_d = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[PKT_BITS-2:0], bus.miso};
          state_d = S_SHIFT;
        end else begin
          phase_d = phase_q + c_PH_W'(1);
        end
      end
      S_SHIFT: begin
        // sclk_q tells which half of the bit period is ending.
        if (w_phase_end) begin
          phase_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bit_d  = bit_q + c_BIT_W'(1);
            tx_d   = {tx_q[PKT_BITS-2:0], 1'b0};
            mosi_d = tx_q[PKT_BITS-2];
          end else if (bit_q == c_BIT_W'(PKT_BITS)) begin
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[PKT_BITS-2:0], bus.miso};
          end
        end else begin
          phase_d = phase_q + c_PH_W'(1);
        end
      end
      S_HOLD: begin
        if (w_phase_end) begin
          phase_d    = '0;
          sc_d       = 1'b0;
          mosi_d     = 1'b0;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          phase_d = phase_q + c_PH_W'(1);
        end
      end
      S_GAP: begin
        if (w_phase_end) begin
          phase_d = '0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + c_PH_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready    = ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.sclk     = sclk_q;
  assign bus.sc       = sc_q;
  assign bus.mosi     = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_spi_host_ctrl: directed bench for spi_host_ctrl, PKT_BITS=8 DIV=2 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spi_host_ctrl;

  logic       mclk;
  logic       rst;
  logic [1:0] miso_mode;   // 0: tie low, 1: tie high, 2: loopback from mosi
  int         checks;
  int         failures;

  spi_host_ctrl_if #(.PKT_BITS(8)) bus ();

  spi_host_ctrl #(.PKT_BITS(8), .DIV(2)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  assign bus.miso = (miso_mode == 2'd2) ? bus.mosi : miso_mode[0];

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Runs one transfer; cycle k after the accepting edge is spec cycle t0+k.
  task automatic xfer(input logic [7:0] tx, input int busy_cyc, input int ign_at,
                      output int t_valid, output int t_ready, output int t_sc,
                      output int rises, output int nvalid, output logic [7:0] mbits,
                      output logic [7:0] rxd, output logic mosi_seen,
                      output logic early, output logic rdy_k1, output logic tmo);
    logic prev_sclk, prev_sc;
    t_valid = -1; t_ready = -1; t_sc = -1; rises = 0; nvalid = 0;
    mbits = '0; rxd = '0; mosi_seen = 1'b0; early = 1'b0; rdy_k1 = 1'b1;
    prev_sclk = 1'b0; prev_sc = 1'b0;
    if (busy_cyc > 0) begin
      bus.rram_busy = 1'b1;
      tick();
      tick();
    end
    bus.tx_data = tx;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 300; k++) begin
      if (k == 1) rdy_k1 = bus.ready;
      if (bus.sclk && !prev_sclk) begin
        rises++;
        mbits = {mbits[6:0], bus.mosi};
      end
      if (bus.mosi) mosi_seen = 1'b1;
      if (bus.sc && !prev_sc && t_sc < 0) t_sc = k;
      if (busy_cyc > 0 && k < busy_cyc + 3 && (bus.sc || bus.sclk)) early = 1'b1;
      if (bus.rx_valid) begin
        nvalid++;
        t_valid = k;
        rxd = bus.rx_data;
      end
      if (bus.ready && k > 1) begin
        t_ready = k;
        break;
      end
      if (busy_cyc > 0 && k == busy_cyc) bus.rram_busy = 1'b0;
      if (k == ign_at) begin
        bus.start   = 1'b1;
        bus.tx_data = 8'h3C;
      end
      if (k == ign_at + 1) bus.start = 1'b0;
      prev_sclk = bus.sclk;
      prev_sc   = bus.sc;
      tick();
    end
    tmo = (t_ready < 0);
  endtask

  task automatic test_reset();
    checks++; if (bus.ready !== 1'b1)    begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if ({bus.sclk, bus.sc, bus.mosi} !== 3'b000) begin
      failures++; $display("FAIL reset_pins got sclk/sc/mosi=%b exp=000", {bus.sclk, bus.sc, bus.mosi});
    end
  endtask

  task automatic test_loopback();
    int tv, tr, ts, ri, nv; logic [7:0] mb, rd; logic ms, er, r1, to;
    miso_mode = 2'd2;
    xfer(8'hA5, 0, -1, tv, tr, ts, ri, nv, mb, rd, ms, er, r1, to);
    checks++; if (to !== 1'b0)   begin failures++; $display("FAIL loop_timeout got=%b exp=0", to); end
    checks++; if (r1 !== 1'b0)   begin failures++; $display("FAIL loop_ready_t1 got=%b exp=0", r1); end
    checks++; if (ts != 2)       begin failures++; $display("FAIL loop_sc_rise got=%0d exp=2", ts); end
    checks++; if (ri != 8)       begin failures++; $display("FAIL loop_sclk_rises got=%0d exp=8", ri); end
    checks++; if (mb !== 8'hA5)  begin failures++; $display("FAIL loop_mosi_bits got=%h exp=a5", mb); end
    checks++; if (tv != 38)      begin failures++; $display("FAIL loop_valid_time got=%0d exp=38", tv); end
    checks++; if (nv != 1)       begin failures++; $display("FAIL loop_valid_count got=%0d exp=1", nv); end
    checks++; if (rd !== 8'hA5)  begin failures++; $display("FAIL loop_rx_data got=%h exp=a5", rd); end
    checks++; if (tr != 40)      begin failures++; $display("FAIL loop_ready_time got=%0d exp=40", tr); end
    checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL loop_rx_hold got=%h exp=a5", bus.rx_data); end
  endtask

  task automatic test_fixed_miso();
    int tv, tr, ts, ri, nv; logic [7:0] mb, rd; logic ms, er, r1, to;
    miso_mode = 2'd1;
    xfer(8'h00, 0, -1, tv, tr, ts, ri, nv, mb, rd, ms, er, r1, to);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL miso1_rx got=%h exp=ff", rd); end
    checks++; if (ms !== 1'b0)  begin failures++; $display("FAIL miso1_mosi_low got=%b exp=0", ms); end
    miso_mode = 2'd0;
    xfer(8'hFF, 0, -1, tv, tr, ts, ri, nv, mb, rd, ms, er, r1, to);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL miso0_rx got=%h exp=00", rd); end
    checks++; if (mb !== 8'hFF) begin failures++; $display("FAIL miso0_mosi_bits got=%h exp=ff", mb); end
  endtask

  task automatic test_busy();
    int tv, tr, ts, ri, nv; logic [7:0] mb, rd; logic ms, er, r1, to;
    miso_mode = 2'd2;
    xfer(8'h69, 10, -1, tv, tr, ts, ri, nv, mb, rd, ms, er, r1, to);
    checks++; if (er !== 1'b0)  begin failures++; $display("FAIL busy_early_sc got=%b exp=0", er); end
    checks++; if (ts != 13)     begin failures++; $display("FAIL busy_sc_rise got=%0d exp=13", ts); end
    checks++; if (tv != 49)     begin failures++; $display("FAIL busy_valid_time got=%0d exp=49", tv); end
    checks++; if (rd !== 8'h69) begin failures++; $display("FAIL busy_rx got=%h exp=69", rd); end
  endtask

  task automatic test_reset_mid();
    int ri, nv;
    logic prev, hit;
    miso_mode = 2'd2;
    ri = 0; prev = 1'b0; hit = 1'b0;
    bus.tx_data = 8'h5A;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.sclk && !prev) ri++;
      if (ri == 4) begin
        hit = 1'b1;
        break;
      end
      prev = bus.sclk;
      tick();
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rstmid_reach_4th got=%b exp=1", hit); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.sc, bus.sclk, bus.mosi} !== 3'b000) begin
      failures++; $display("FAIL rstmid_pins got sc/sclk/mosi=%b exp=000", {bus.sc, bus.sclk, bus.mosi});
    end
    checks++; if (bus.ready !== 1'b1)    begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx_data got=%h exp=00", bus.rx_data); end
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.rx_valid) nv++;
      tick();
    end
    checks++; if (nv != 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", nv); end
  endtask

  task automatic test_ignored_start();
    int tv, tr, ts, ri, nv; logic [7:0] mb, rd; logic ms, er, r1, to;
    miso_mode = 2'd2;
    xfer(8'hC3, 0, 10, tv, tr, ts, ri, nv, mb, rd, ms, er, r1, to);
    checks++; if (mb !== 8'hC3) begin failures++; $display("FAIL ign_mosi_bits got=%h exp=c3", mb); end
    checks++; if (nv != 1)      begin failures++; $display("FAIL ign_valid_count got=%0d exp=1", nv); end
    checks++; if (rd !== 8'hC3) begin failures++; $display("FAIL ign_rx got=%h exp=c3", rd); end
    for (int k = 0; k < 50; k++) tick();
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL ign_no_requeue got ready=%b exp=1", bus.ready); end
  endtask

  task automatic test_back_to_back();
    int nv, t_v1, t_v2, t_fall, t_rise2;
    logic [7:0] rx1, rx2;
    logic prev_sc;
    miso_mode = 2'd2;
    nv = 0; t_v1 = -1; t_v2 = -1; t_fall = -1; t_rise2 = -1;
    rx1 = '0; rx2 = '0; prev_sc = 1'b0;
    bus.tx_data = 8'h12;
    bus.start   = 1'b1;
    tick();
    for (int k = 1; k < 300; k++) begin
      if (k == 1) bus.tx_data = 8'h34;
      if (!bus.sc && prev_sc && t_fall < 0) t_fall = k;
      if (bus.sc && !prev_sc && t_fall > 0 && t_rise2 < 0) t_rise2 = k;
      if (bus.rx_valid) begin
        nv++;
        if (nv == 1) begin t_v1 = k; rx1 = bus.rx_data; end
        if (nv == 2) begin t_v2 = k; rx2 = bus.rx_data; end
      end
      if (nv == 2) break;
      prev_sc = bus.sc;
      tick();
    end
    bus.start = 1'b0;
    checks++; if (nv != 2)       begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", nv); end
    checks++; if (rx1 !== 8'h12) begin failures++; $display("FAIL b2b_rx_first got=%h exp=12", rx1); end
    checks++; if (rx2 !== 8'h34) begin failures++; $display("FAIL b2b_rx_second got=%h exp=34", rx2); end
    checks++; if (t_v1 != 38 || t_v2 != 78) begin
      failures++; $display("FAIL b2b_valid_times got=%0d,%0d exp=38,78", t_v1, t_v2);
    end
    checks++; if (t_rise2 - t_fall != 4) begin
      failures++; $display("FAIL b2b_sc_low got=%0d exp=4", t_rise2 - t_fall);
    end
    for (int k = 0; k < 60; k++) tick();
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_after got ready=%b exp=1", bus.ready); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    miso_mode     = 2'd0;
    bus.start     = 1'b0;
    bus.tx_data   = '0;
    bus.rram_busy = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_loopback();
    test_fixed_miso();
    test_busy();
    test_loopback();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
